// File: rtl/pong_pkg.sv
// Shared pong definitions: FSM state encoding, default game parameters and
// small helpers used by the serve controller.
package pong_pkg;

  // Default game parameters
  localparam int DEF_COUNT_FRAMES = 60;
  localparam int DEF_WIN_SCORE    = 9;

  // Serve FSM state encoding (kept as plain constants for legacy tools)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_COUNTDOWN = 3'd1;
  localparam state_t ST_SERVE     = 3'd2;
  localparam state_t ST_PLAY      = 3'd3;
  localparam state_t ST_GAMEOVER  = 3'd4;

  // Vertical speed from two random bits: always in 1..4 px/frame
  function automatic logic [2:0] serve_speed(input logic [1:0] r);
    return 3'd1 + {1'b0, r};
  endfunction

endpackage

// File: rtl/ball_serve.sv
// Ball serve controller: runs the pre-serve countdown, launches the ball with
// randomised vertical parameters, keeps score and detects the end of the game.
// The rnd port is numbered [2:0] here; the LFSR documentation calls rnd[2]
// "bit 1" (MSB), rnd[1] "bit 2" and rnd[0] "bit 3".
module ball_serve
  import pong_pkg::*;
#(
  parameter int COUNT_FRAMES = DEF_COUNT_FRAMES,
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int X_CENTER     = 320,
  parameter int Y_CENTER     = 240,
  parameter int Y_STEP       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic [2:0]  rnd,
  input  logic        point_p1,
  input  logic        point_p2,
  output logic        serve_valid,
  output logic [10:0] serve_x,
  output logic [9:0]  serve_y,
  output logic        dir_x,
  output logic        dir_y,
  output logic [2:0]  speed_y,
  output logic        active,
  output logic [7:0]  count,
  output logic [3:0]  score_p1,
  output logic [3:0]  score_p2,
  output logic        game_over,
  output logic        winner
);

  localparam logic [7:0]  COUNT_LOAD = 8'(COUNT_FRAMES);
  localparam logic [3:0]  WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [3:0]  WIN_M1     = 4'(WIN_SCORE - 1);
  localparam logic [10:0] SERVE_X    = 11'(X_CENTER);
  localparam logic [9:0]  Y_REST     = 10'(Y_CENTER);
  localparam logic [9:0]  Y_LOW      = 10'(Y_CENTER + Y_STEP);
  localparam logic [9:0]  Y_HIGH     = 10'(Y_CENTER - Y_STEP);

  state_t state_reg;
  state_t state_next;
  logic   start_d_reg;
  logic   dir_pending_reg;

  logic start_rise;
  logic game_start;
  logic p1_hit;
  logic p2_hit;
  logic p1_win;
  logic p2_win;
  logic last_tick;

  // Decode the events the registers react to in the current state
  always_comb begin
    start_rise = start & ~start_d_reg;
    // IDLE reacts to the start level, GAMEOVER needs a fresh press
    game_start = ((state_reg == ST_IDLE) & start) |
                 ((state_reg == ST_GAMEOVER) & start_rise);
    // Points only count during play; P1 has priority on a tie
    p1_hit     = (state_reg == ST_PLAY) & point_p1;
    p2_hit     = (state_reg == ST_PLAY) & point_p2 & ~point_p1;
    p1_win     = p1_hit & (score_p1 >= WIN_M1);
    p2_win     = p2_hit & (score_p2 >= WIN_M1);
    last_tick  = (state_reg == ST_COUNTDOWN) & tick & (count == 8'd1);
  end

  // Next-state logic for the serve FSM
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (game_start) state_next = ST_COUNTDOWN;
      end
      ST_COUNTDOWN: begin
        if (last_tick) state_next = ST_SERVE;
      end
      ST_SERVE: begin
        state_next = ST_PLAY;
      end
      ST_PLAY: begin
        if (p1_win || p2_win)      state_next = ST_GAMEOVER;
        else if (p1_hit || p2_hit) state_next = ST_COUNTDOWN;
      end
      ST_GAMEOVER: begin
        if (game_start) state_next = ST_COUNTDOWN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register, start edge detector and state-derived output flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      start_d_reg <= 1'b0;
      serve_valid <= 1'b0;
      active      <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      start_d_reg <= start;
      // High for exactly the one cycle spent in SERVE
      serve_valid <= last_tick;
      active      <= (state_next == ST_PLAY);
      game_over   <= (state_next == ST_GAMEOVER);
    end
  end

  // Countdown counter: reload on game start or a non-final point, tick down otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (game_start) begin
      count <= COUNT_LOAD;
    end else if ((p1_hit && !p1_win) || (p2_hit && !p2_win)) begin
      count <= COUNT_LOAD;
    end else if ((state_reg == ST_COUNTDOWN) && tick && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  // Score registers and winner flag; scores saturate at the winning value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_p1 <= 4'd0;
      score_p2 <= 4'd0;
      winner   <= 1'b0;
    end else if (game_start) begin
      score_p1 <= 4'd0;
      score_p2 <= 4'd0;
      winner   <= 1'b0;
    end else if (p1_hit) begin
      if (score_p1 < WIN_VAL) score_p1 <= score_p1 + 4'd1;
      if (p1_win)             winner   <= 1'b0;
    end else if (p2_hit) begin
      if (score_p2 < WIN_VAL) score_p2 <= score_p2 + 4'd1;
      if (p2_win)             winner   <= 1'b1;
    end
  end

  // Serve direction: the ball goes toward whoever lost the last point
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_pending_reg <= 1'b1;
    end else if (game_start) begin
      dir_pending_reg <= 1'b1;
    end else if (p1_hit) begin
      dir_pending_reg <= 1'b1;
    end else if (p2_hit) begin
      dir_pending_reg <= 1'b0;
    end
  end

  // Serve parameters: captured on entry to SERVE and held until the next serve
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      serve_x <= SERVE_X;
      serve_y <= Y_REST;
      dir_x   <= 1'b1;
      dir_y   <= 1'b0;
      speed_y <= 3'd1;
    end else if (last_tick) begin
      serve_x <= SERVE_X;
      serve_y <= rnd[1] ? Y_LOW : Y_HIGH;
      dir_x   <= dir_pending_reg;
      dir_y   <= rnd[0];
      speed_y <= serve_speed(rnd[2:1]);
    end else if (game_start) begin
      // A new game always opens toward P2
      dir_x   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ball_serve.sv
// Self-checking bench for ball_serve: expected serves are queued when the
// random bits are driven and compared when serve_valid appears.
module tb_ball_serve;

  localparam int CF   = 3;
  localparam int WS   = 2;
  localparam int XC   = 320;
  localparam int YC   = 240;
  localparam int YS   = 16;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        start;
  logic [2:0]  rnd;
  logic        point_p1;
  logic        point_p2;
  logic        serve_valid;
  logic [10:0] serve_x;
  logic [9:0]  serve_y;
  logic        dir_x;
  logic        dir_y;
  logic [2:0]  speed_y;
  logic        active;
  logic [7:0]  count;
  logic [3:0]  score_p1;
  logic [3:0]  score_p2;
  logic        game_over;
  logic        winner;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        dx;
    logic        dy;
    logic [2:0]  sp;
  } serve_t;

  serve_t exp_q[$];
  serve_t mon_exp;
  int     checks   = 0;
  int     failures = 0;

  ball_serve #(
    .COUNT_FRAMES (CF),
    .WIN_SCORE    (WS),
    .X_CENTER     (XC),
    .Y_CENTER     (YC),
    .Y_STEP       (YS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .start       (start),
    .rnd         (rnd),
    .point_p1    (point_p1),
    .point_p2    (point_p2),
    .serve_valid (serve_valid),
    .serve_x     (serve_x),
    .serve_y     (serve_y),
    .dir_x       (dir_x),
    .dir_y       (dir_y),
    .speed_y     (speed_y),
    .active      (active),
    .count       (count),
    .score_p1    (score_p1),
    .score_p2    (score_p2),
    .game_over   (game_over),
    .winner      (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference serve: rnd[2] is the LFSR MSB ("bit 1"), rnd[0] is "bit 3"
  function automatic serve_t model_serve(input logic [2:0] r, input logic dx);
    serve_t s;
    s.x  = 11'(XC);
    s.y  = r[1] ? 10'(YC + YS) : 10'(YC - YS);
    s.dx = dx;
    s.dy = r[0];
    s.sp = 3'd1 + {1'b0, r[2:1]};
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic queue_serve(input logic [2:0] r, input logic dx);
    rnd = r;
    exp_q.push_back(model_serve(r, dx));
  endtask

  // Scoreboard: every serve_valid pulse must match the oldest queued serve
  always @(negedge clk) begin
    if (!rst && serve_valid) begin
      if (exp_q.size() == 0) begin
        check_val("serve_unexpected", 32'(serve_valid), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("serve x=%0d y=%0d dir_x=%0d dir_y=%0d speed=%0d", serve_x, serve_y, dir_x, dir_y, speed_y);
        check_val("serve_x", 32'(serve_x), 32'(mon_exp.x));
        check_val("serve_y", 32'(serve_y), 32'(mon_exp.y));
        check_val("serve_dir_x", 32'(dir_x), 32'(mon_exp.dx));
        check_val("serve_dir_y", 32'(dir_y), 32'(mon_exp.dy));
        check_val("serve_speed", 32'(speed_y), 32'(mon_exp.sp));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; start = 1'b0; rnd = 3'b000;
    point_p1 = 1'b0; point_p2 = 1'b0;
    repeat (2) step();

    // Reset values
    check_val("rst_serve_valid", 32'(serve_valid), 32'd0);
    check_val("rst_active", 32'(active), 32'd0);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_dir_x", 32'(dir_x), 32'd1);
    check_val("rst_dir_y", 32'(dir_y), 32'd0);
    check_val("rst_speed", 32'(speed_y), 32'd1);
    check_val("rst_serve_x", 32'(serve_x), 32'd320);
    check_val("rst_serve_y", 32'(serve_y), 32'd240);
    check_val("rst_game_over", 32'(game_over), 32'd0);
    rst = 1'b0;
    step();
    check_val("idle_count", 32'(count), 32'd0);

    // Start from IDLE loads the countdown
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("start_count", 32'(count), 32'(CF));
    check_val("start_score_p1", 32'(score_p1), 32'd0);
    queue_serve(3'b101, 1'b1);
    tick_once();
    check_val("cd_count2", 32'(count), 32'd2);
    // Point pulse during countdown is ignored, tick still counts
    tick = 1'b1; point_p1 = 1'b1;
    step();
    tick = 1'b0; point_p1 = 1'b0;
    check_val("cd_count1", 32'(count), 32'd1);
    check_val("cd_point_ignored", 32'(score_p1), 32'd0);
    tick_once();
    check_val("serve_pulse", 32'(serve_valid), 32'd1);
    check_val("serve_not_active", 32'(active), 32'd0);
    check_val("serve_count0", 32'(count), 32'd0);
    step();
    check_val("play_active", 32'(active), 32'd1);
    check_val("play_valid_low", 32'(serve_valid), 32'd0);
    check_val("play_serve_y", 32'(serve_y), 32'd224);
    // Parameters hold when rnd moves during play
    rnd = 3'b010;
    tick_once();
    check_val("hold_speed", 32'(speed_y), 32'd3);
    check_val("hold_dir_y", 32'(dir_y), 32'd1);
    check_val("play_tick_count", 32'(count), 32'd0);

    // P2 scores: next serve heads toward P1
    point_p2 = 1'b1;
    step();
    point_p2 = 1'b0;
    check_val("p2_score", 32'(score_p2), 32'd1);
    check_val("p2_reload", 32'(count), 32'(CF));
    check_val("p2_inactive", 32'(active), 32'd0);
    check_val("p2_dir_x_held", 32'(dir_x), 32'd1);
    queue_serve(3'b010, 1'b0);
    repeat (CF) tick_once();
    step();
    check_val("serve2_dir_x", 32'(dir_x), 32'd0);
    check_val("serve2_active", 32'(active), 32'd1);

    // Simultaneous points: P1 wins the tie
    point_p1 = 1'b1; point_p2 = 1'b1;
    step();
    point_p1 = 1'b0; point_p2 = 1'b0;
    check_val("tie_score_p1", 32'(score_p1), 32'd1);
    check_val("tie_score_p2", 32'(score_p2), 32'd1);
    check_val("tie_reload", 32'(count), 32'(CF));
    queue_serve(3'b111, 1'b1);
    repeat (CF) tick_once();
    step();
    // Start during play is ignored and then held across the game end
    start = 1'b1;
    step();
    check_val("start_in_play", 32'(active), 32'd1);
    point_p1 = 1'b1;
    step();
    point_p1 = 1'b0;
    check_val("go_flag", 32'(game_over), 32'd1);
    check_val("go_winner", 32'(winner), 32'd0);
    check_val("go_score_p1", 32'(score_p1), 32'(WS));
    check_val("go_inactive", 32'(active), 32'd0);
    repeat (3) step();
    check_val("go_held_start", 32'(game_over), 32'd1);
    point_p2 = 1'b1;
    step();
    point_p2 = 1'b0;
    check_val("go_point_ignored", 32'(score_p2), 32'd1);
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check_val("restart_go", 32'(game_over), 32'd0);
    check_val("restart_p1", 32'(score_p1), 32'd0);
    check_val("restart_p2", 32'(score_p2), 32'd0);
    check_val("restart_count", 32'(count), 32'(CF));
    check_val("restart_dir_x", 32'(dir_x), 32'd1);

    // Reset mid-play: immediate return to reset values
    queue_serve(3'b000, 1'b1);
    repeat (CF) tick_once();
    step();
    check_val("play3_active", 32'(active), 32'd1);
    rst = 1'b1;
    #1;
    check_val("arst_active", 32'(active), 32'd0);
    check_val("arst_serve_y", 32'(serve_y), 32'd240);
    check_val("arst_speed", 32'(speed_y), 32'd1);
    check_val("arst_count", 32'(count), 32'd0);
    step();
    rst = 1'b0;
    repeat (2) step();
    check_val("arst_release_valid", 32'(serve_valid), 32'd0);

    // Reset one tick before the serve discards it
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (CF - 1) tick_once();
    check_val("cd2_count1", 32'(count), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) tick_once();
    check_val("cd2_idle_count", 32'(count), 32'd0);
    check_val("cd2_idle_active", 32'(active), 32'd0);

    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
